// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// rf_pkg : shared state encoding and default sizes for the rf_param file
// Revision: 1.0
// ============================================================================
package rf_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } rf_state_e;

   localparam int RF_W  = 32;
   localparam int RF_AW = 3;
   localparam int RF_NR = 2;

endpackage
`default_nettype wire

// File: rtl/rf_param_if.sv
`default_nettype none
// ============================================================================
// rf_param_if : decode/write-back side bus of the parametrised register file
// Revision: 1.0
// ============================================================================
interface rf_param_if
   import rf_pkg::*;
#(
   parameter int W  = RF_W,
   parameter int AW = RF_AW,
   parameter int NR = RF_NR
) ();

   logic             clr_start;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [W-1:0]     wr_data;
   logic             rsv_en;
   logic [AW-1:0]    rsv_addr;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*W-1:0]  rd_data;
   logic [NR-1:0]    rd_busy;
   logic             ready;

   modport master (
      output clr_start, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
      input  rd_data, rd_busy, ready
   );

   modport slave (
      input  clr_start, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
      output rd_data, rd_busy, ready
   );

endinterface
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// rf_read_port : one combinational read port (mux, bypass, r0, not-ready mask)
// Revision: 1.0
// ============================================================================
module rf_read_port #(
   parameter int W       = 32,
   parameter int AW      = 3,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
) (
   input  wire logic                   ready_i,
   input  wire logic [AW-1:0]          rd_addr_i,
   input  wire logic [(2**AW)*W-1:0]   mem_i,
   input  wire logic [(2**AW)-1:0]     busy_i,
   input  wire logic                   wr_en_i,
   input  wire logic [AW-1:0]          wr_addr_i,
   input  wire logic [W-1:0]           wr_data_i,
   input  wire logic                   rsv_en_i,
   input  wire logic [AW-1:0]          rsv_addr_i,
   output logic      [W-1:0]           rd_data_o,
   output logic                        rd_busy_o
);

   logic w_zero;
   logic w_byp;

   assign w_zero = (ZERO_R0 != 0) && (rd_addr_i == '0);
   assign w_byp  = (BYPASS != 0) && wr_en_i && (rd_addr_i == wr_addr_i);

   // Hardwired r0 takes priority over the bypass path.
   always_comb begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
      if (ready_i && !w_zero) begin
         if (w_byp) begin
            rd_data_o = wr_data_i;
            rd_busy_o = rsv_en_i && (rsv_addr_i == wr_addr_i);
         end else begin
            rd_data_o = mem_i[int'(rd_addr_i)*W +: W];
            rd_busy_o = busy_i[rd_addr_i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rf_param.sv
`default_nettype none
// ============================================================================
// rf_param : parametrised register file with busy scoreboard and clear sequencer
// Revision: 1.0
// ============================================================================
module rf_param
   import rf_pkg::*;
#(
   parameter int W       = RF_W,
   parameter int AW      = RF_AW,
   parameter int NR      = RF_NR,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 0
) (
   input wire logic  clk,
   input wire logic  reset,
   rf_param_if.slave bus
);

   localparam int DEPTH = 2**AW;

   rf_state_e          state_q, state_d;
   logic [AW-1:0]      cnt_q, cnt_d;
   logic [DEPTH-1:0]   busy_q, busy_d;
   logic [W-1:0]       mem_q [DEPTH];
   logic [DEPTH*W-1:0] w_mem_flat;

   logic               w_ready;
   logic               w_wr_ok;
   logic               w_rsv_ok;
   logic               w_mem_we;
   logic [AW-1:0]      w_mem_waddr;
   logic [W-1:0]       w_mem_wdata;
   logic [NR*W-1:0]    w_rd_data;
   logic [NR-1:0]      w_rd_busy;

   assign w_ready  = (state_q == IDLE);
   assign w_wr_ok  = bus.wr_en  && !((ZERO_R0 != 0) && (bus.wr_addr  == '0));
   assign w_rsv_ok = bus.rsv_en && !((ZERO_R0 != 0) && (bus.rsv_addr == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // Reserve is applied after the write so a new producer keeps the entry busy.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      w_mem_we    = 1'b0;
      w_mem_waddr = bus.wr_addr;
      w_mem_wdata = bus.wr_data;
      case (state_q)
         CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = cnt_q;
            w_mem_wdata = '0;
            cnt_d       = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         IDLE: begin
            if (bus.clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
               busy_d  = '0;
            end else begin
               if (w_wr_ok) begin
                  w_mem_we             = 1'b1;
                  busy_d[bus.wr_addr]  = 1'b0;
               end
               if (w_rsv_ok) begin
                  busy_d[bus.rsv_addr] = 1'b1;
               end
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Storage has no reset so it can map onto RAM; the clear sequence zeroes it.
   always_ff @(posedge clk) begin
      if (!reset && w_mem_we) begin
         mem_q[w_mem_waddr] <= w_mem_wdata;
      end
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_flat
      assign w_mem_flat[e*W +: W] = mem_q[e];
   end

   for (genvar p = 0; p < NR; p++) begin : g_rd
      rf_read_port #(
         .W       (W),
         .AW      (AW),
         .BYPASS  (BYPASS),
         .ZERO_R0 (ZERO_R0)
      ) u_port (
         .ready_i    (w_ready),
         .rd_addr_i  (bus.rd_addr[p*AW +: AW]),
         .mem_i      (w_mem_flat),
         .busy_i     (busy_q),
         .wr_en_i    (bus.wr_en),
         .wr_addr_i  (bus.wr_addr),
         .wr_data_i  (bus.wr_data),
         .rsv_en_i   (bus.rsv_en),
         .rsv_addr_i (bus.rsv_addr),
         .rd_data_o  (w_rd_data[p*W +: W]),
         .rd_busy_o  (w_rd_busy[p])
      );
   end

   assign bus.rd_data = w_rd_data;
   assign bus.rd_busy = w_rd_busy;
   assign bus.ready   = w_ready;

endmodule
`default_nettype wire
